// File: rtl/store_buffer_if.sv
//------------------------------------------------------------------------------
// store_buffer_if
// CPU request/response and data-memory port bundle for the store buffer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface store_buffer_if;
  // CPU side
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        buf_empty;
  // Data-memory side
  logic [15:0] mem_addr;
  logic [15:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [15:0] mem_read_data;

  // Environment: CPU issuing requests plus the word memory
  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_read_data,
    input  req_ready, rsp_valid, rsp_data, buf_empty,
           mem_addr, mem_write_data, mem_write, mem_read
  );

  // Store buffer itself
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_read_data,
    output req_ready, rsp_valid, rsp_data, buf_empty,
           mem_addr, mem_write_data, mem_write, mem_read
  );
endinterface

`default_nettype wire

// File: rtl/store_buffer.sv
//------------------------------------------------------------------------------
// store_buffer
// Posted-write store FIFO with youngest-match store-to-load forwarding.
// Loads own the memory port when present; stores drain one per idle cycle.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  store_buffer_if.slave bus
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  // Entry storage: word address and data
  logic [14:0]        r_ent_addr [DEPTH];
  logic [15:0]        r_ent_data [DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;
  logic               r_rsp_valid;
  logic [15:0]        r_rsp_data;

  logic               w_full;
  logic               w_ready;
  logic               w_load;
  logic               w_store;
  logic               w_drain;
  logic               w_hit;
  logic [15:0]        w_fwd_data;
  logic [c_PTR_W-1:0] w_slot [DEPTH];

  assign w_full  = (r_count == c_FULL);
  assign w_ready = !w_full;
  assign w_load  = bus.req_valid && !bus.req_write && w_ready;
  assign w_store = bus.req_valid &&  bus.req_write && w_ready;
  // A load always wins the port; otherwise any pending store retires
  assign w_drain = !w_load && (r_count != '0);

  // Slot i is the i-th oldest entry counted from head
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign w_slot[gi] = r_head + c_PTR_W'(gi);
  end

  // Scan oldest to youngest so the youngest matching entry is the last to win
  always_comb begin
    w_hit      = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((c_CNT_W'(i) < r_count) &&
          (r_ent_addr[w_slot[i]] == bus.req_addr[15:1])) begin
        w_hit      = 1'b1;
        w_fwd_data = r_ent_data[w_slot[i]];
      end
    end
  end

  // Memory port mux: load, drain, or idle with everything driven low
  always_comb begin
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;
    if (w_load) begin
      bus.mem_read = 1'b1;
      bus.mem_addr = bus.req_addr;
    end else if (w_drain) begin
      bus.mem_write      = 1'b1;
      bus.mem_addr       = {r_ent_addr[r_head], 1'b0};
      bus.mem_write_data = r_ent_data[r_head];
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.buf_empty = (r_count == '0);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;

  // Capture an accepted store into the tail slot; contents need no reset
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_ent_addr[r_tail] <= bus.req_addr[15:1];
      r_ent_data[r_tail] <= bus.req_wdata;
    end
  end

  // Pointer and occupancy bookkeeping; reset discards pending stores
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_store) r_tail <= r_tail + 1'b1;
      if (w_drain) r_head <= r_head + 1'b1;
      r_count <= r_count + c_CNT_W'(w_store) - c_CNT_W'(w_drain);
    end
  end

  // Register the load result: forwarded data if buffered, else memory
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_load;
      if (w_load) r_rsp_data <= w_hit ? w_fwd_data : bus.mem_read_data;
    end
  end

endmodule

`default_nettype wire
